// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
//
// Moore control FSM that sequences a CNN training / inference run over a
// separate datapath. Each step raises a request and waits for the matching
// completion strobe. Weights are loaded once per run (conv sets first, then FC).
// Each image then goes through fetch, answer fetch and the forward passes. In
// train mode the FC and conv back-propagation passes follow. A weight update
// runs after every BATCH_SIZE images and after a short final batch.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, mode_train,
//   num_images, abort     run control (mode/num_images latched on start)
//   done_*                datapath completion strobes, one per request
//   *_req, *_sel          step requests and layer selects toward the datapath
//   busy, run_done,
//   aborted               status (run_done and aborted are one-cycle pulses)
//   img_cnt, batch_cnt    completed images / images since last update
// -----------------------------------------------------------------------------
module train_sequencer #(
    parameter int N_CONV     = 3,
    parameter int N_FC       = 2,
    parameter int BATCH_SIZE = 32,
    parameter int IMG_W      = 16,
    localparam int LW        = (N_CONV + N_FC > 1) ? $clog2(N_CONV + N_FC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_train,
    input  logic [IMG_W-1:0] num_images,
    input  logic             abort,
    input  logic             done_wload,
    input  logic             done_img,
    input  logic             done_ans,
    input  logic             done_fwd,
    input  logic             done_fc_bp,
    input  logic             done_conv_bp,
    input  logic             done_update,
    output logic             wload_req,
    output logic [LW-1:0]    wload_sel,
    output logic             img_req,
    output logic             ans_req,
    output logic             fwd_req,
    output logic [LW-1:0]    fwd_sel,
    output logic             fc_bp_req,
    output logic             conv_bp_req,
    output logic [LW-1:0]    conv_bp_sel,
    output logic             update_req,
    output logic             busy,
    output logic             run_done,
    output logic             aborted,
    output logic [IMG_W-1:0] img_cnt,
    output logic [IMG_W-1:0] batch_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_WLOAD, S_IMG, S_ANS, S_FWD, S_FC_BP, S_CONV_BP, S_UPDATE, S_FINISH
    } state_t;

    localparam logic [LW-1:0]    IDX_ONE    = LW'(1);
    localparam logic [LW-1:0]    WLOAD_LAST = LW'(N_CONV + N_FC - 1);
    localparam logic [LW-1:0]    FWD_LAST   = LW'(N_CONV);   // index N_CONV = FC forward
    localparam logic [LW-1:0]    CONV_TOP   = LW'(N_CONV - 1);
    localparam logic [IMG_W-1:0] IMG_ONE    = IMG_W'(1);
    localparam logic [IMG_W-1:0] BATCH_LIM  = IMG_W'(BATCH_SIZE);

    state_t           state_reg, state_next;
    logic [LW-1:0]    idx_reg, idx_next;        // shared layer index for all sel outputs
    logic [IMG_W-1:0] img_reg, img_next;
    logic [IMG_W-1:0] batch_reg, batch_next;
    logic [IMG_W-1:0] num_reg, num_next;
    logic             mode_reg, mode_next;
    logic             aborted_reg, aborted_next;
    logic [IMG_W-1:0] img_inc, batch_inc;

    assign img_inc   = img_reg + IMG_ONE;
    assign batch_inc = batch_reg + IMG_ONE;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            img_reg     <= '0;
            batch_reg   <= '0;
            num_reg     <= '0;
            mode_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            img_reg     <= img_next;
            batch_reg   <= batch_next;
            num_reg     <= num_next;
            mode_reg    <= mode_next;
            aborted_reg <= aborted_next;
        end
    end

    // Next-state logic. Each done strobe is looked at only in its own state,
    // and abort overrides whatever strobe arrives with it.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        img_next     = img_reg;
        batch_next   = batch_reg;
        num_next     = num_reg;
        mode_next    = mode_reg;
        aborted_next = 1'b0;

        if (abort && state_reg != S_IDLE) begin
            state_next   = S_IDLE;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    mode_next  = mode_train;
                    num_next   = num_images;
                    img_next   = '0;
                    batch_next = '0;
                    idx_next   = '0;
                    state_next = S_WLOAD;
                end
                S_WLOAD: if (done_wload) begin
                    if (idx_reg == WLOAD_LAST) begin
                        idx_next   = '0;
                        state_next = (num_reg == '0) ? S_FINISH : S_IMG;
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                    end
                end
                S_IMG: if (done_img) state_next = S_ANS;
                S_ANS: if (done_ans) begin
                    idx_next   = '0;
                    state_next = S_FWD;
                end
                S_FWD: if (done_fwd) begin
                    if (idx_reg != FWD_LAST) begin
                        idx_next = idx_reg + IDX_ONE;
                    end else if (mode_reg) begin
                        state_next = S_FC_BP;
                    end else begin
                        img_next   = img_inc;
                        state_next = (img_inc == num_reg) ? S_FINISH : S_IMG;
                    end
                end
                S_FC_BP: if (done_fc_bp) begin
                    idx_next   = CONV_TOP;
                    state_next = S_CONV_BP;
                end
                S_CONV_BP: if (done_conv_bp) begin
                    if (idx_reg != '0) begin
                        idx_next = idx_reg - IDX_ONE;
                    end else begin
                        img_next   = img_inc;
                        batch_next = batch_inc;
                        // A short final batch still gets its own update.
                        state_next = (batch_inc == BATCH_LIM || img_inc == num_reg)
                                     ? S_UPDATE : S_IMG;
                    end
                end
                S_UPDATE: if (done_update) begin
                    batch_next = '0;
                    state_next = (img_reg == num_reg) ? S_FINISH : S_IMG;
                end
                S_FINISH: state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        wload_req   = 1'b0;
        wload_sel   = '0;
        img_req     = 1'b0;
        ans_req     = 1'b0;
        fwd_req     = 1'b0;
        fwd_sel     = '0;
        fc_bp_req   = 1'b0;
        conv_bp_req = 1'b0;
        conv_bp_sel = '0;
        update_req  = 1'b0;
        run_done    = 1'b0;
        case (state_reg)
            S_WLOAD:   begin wload_req = 1'b1; wload_sel = idx_reg; end
            S_IMG:     img_req = 1'b1;
            S_ANS:     ans_req = 1'b1;
            S_FWD:     begin fwd_req = 1'b1; fwd_sel = idx_reg; end
            S_FC_BP:   fc_bp_req = 1'b1;
            S_CONV_BP: begin conv_bp_req = 1'b1; conv_bp_sel = idx_reg; end
            S_UPDATE:  update_req = 1'b1;
            S_FINISH:  run_done = 1'b1;
            default:   ;
        endcase
    end

    assign busy      = (state_reg != S_IDLE);
    assign aborted   = aborted_reg;
    assign img_cnt   = img_reg;
    assign batch_cnt = batch_reg;

endmodule
